// File: rtl/skin_bin_pkg.sv
// rtl/skin_bin_pkg.sv - shared constants for the skin-binarization config/stats controller
package skin_bin_pkg;

  localparam int PIX_W    = 8;
  localparam int NUM_REGS = 8;

  localparam int IDX_R_MIN  = 0;
  localparam int IDX_S_MIN  = 1;
  localparam int IDX_S_MAX  = 2;
  localparam int IDX_H_MAX  = 3;
  localparam int IDX_CB_MIN = 4;
  localparam int IDX_CB_MAX = 5;
  localparam int IDX_CR_MIN = 6;
  localparam int IDX_CR_MAX = 7;

  localparam logic [7:0] DEF_R_MIN  = 8'd95;
  localparam logic [7:0] DEF_S_MIN  = 8'd23;
  localparam logic [7:0] DEF_S_MAX  = 8'd174;
  localparam logic [7:0] DEF_H_MAX  = 8'd50;
  localparam logic [7:0] DEF_CB_MIN = 8'd77;
  localparam logic [7:0] DEF_CB_MAX = 8'd127;
  localparam logic [7:0] DEF_CR_MIN = 8'd133;
  localparam logic [7:0] DEF_CR_MAX = 8'd173;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    RUN        = 2'd1,
    COMMIT     = 2'd2
  } ctrl_state_e;

  // Register k occupies bits [8k+7:8k] of the flattened bank.
  function automatic logic [8*NUM_REGS-1:0] default_bank();
    logic [8*NUM_REGS-1:0] b;
    b = '0;
    b[8*IDX_R_MIN  +: 8] = DEF_R_MIN;
    b[8*IDX_S_MIN  +: 8] = DEF_S_MIN;
    b[8*IDX_S_MAX  +: 8] = DEF_S_MAX;
    b[8*IDX_H_MAX  +: 8] = DEF_H_MAX;
    b[8*IDX_CB_MIN +: 8] = DEF_CB_MIN;
    b[8*IDX_CB_MAX +: 8] = DEF_CB_MAX;
    b[8*IDX_CR_MIN +: 8] = DEF_CR_MIN;
    b[8*IDX_CR_MAX +: 8] = DEF_CR_MAX;
    return b;
  endfunction

endpackage

// File: rtl/skin_frame_stats.sv
// rtl/skin_frame_stats.sv - vsync edge detect and saturating per-frame skin-pixel counter
module skin_frame_stats
  import skin_bin_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             de,
  input  logic             vsync,
  input  logic [PIX_W-1:0] skin,
  input  logic             count_en,
  output logic             fe,
  output logic [CNT_W-1:0] count_hold
);

  logic             vsync_d;
  logic             qual;
  logic [CNT_W-1:0] counter;

  assign fe   = ce & vsync & ~vsync_d;
  assign qual = ce & de & (skin != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
    end else if (ce) begin
      vsync_d <= vsync;
    end
  end

  // The pixel sampled on the frame-edge cycle already belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= '0;
      count_hold <= '0;
    end else if (fe) begin
      count_hold <= counter;
      counter    <= {{(CNT_W-1){1'b0}}, qual};
    end else if (!count_en) begin
      counter <= '0;
    end else if (qual && !(&counter)) begin
      counter <= counter + 1'b1;
    end
  end

endmodule

// File: rtl/skin_bin_ctrl.sv
// rtl/skin_bin_ctrl.sv - shadow/active threshold banks with frame-boundary commit and frame statistics
module skin_bin_ctrl
  import skin_bin_pkg::*;
#(
  parameter int CNT_W  = 22,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              de,
  input  logic              vsync,
  input  logic [PIX_W-1:0]  skin,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              cfg_pending,
  output logic [63:0]       thr_active,
  output logic [CNT_W-1:0]  skin_count,
  output logic              stats_valid,
  output logic [FCNT_W-1:0] frame_cnt
);

  ctrl_state_e      state, state_nxt;
  logic             report, report_nxt;
  logic             in_commit;
  logic             count_en;
  logic             fe;
  logic [CNT_W-1:0] count_hold;
  logic             wr_acc;
  logic [63:0]      shadow;
  logic [63:0]      snap;
  logic             snap_go;
  logic             late_wr;

  skin_frame_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .de         (de),
    .vsync      (vsync),
    .skin       (skin),
    .count_en   (count_en),
    .fe         (fe),
    .count_hold (count_hold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT_FRAME;
      report <= 1'b0;
    end else begin
      state  <= state_nxt;
      report <= report_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    report_nxt = report;
    in_commit  = 1'b0;
    count_en   = 1'b1;
    case (state)
      WAIT_FRAME: begin
        count_en = 1'b0;
        if (fe) begin
          state_nxt  = COMMIT;
          report_nxt = 1'b0;
        end
      end
      RUN: begin
        if (fe) begin
          state_nxt  = COMMIT;
          report_nxt = 1'b1;
        end
      end
      COMMIT: begin
        in_commit = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

  assign wr_ready = ~in_commit;
  assign wr_acc   = wr_en & ~in_commit;

  // The bank to commit is snapshotted at the frame edge, so a write landing
  // on that same cycle stays pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= default_bank();
      thr_active  <= default_bank();
      snap        <= default_bank();
      snap_go     <= 1'b0;
      late_wr     <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      if (fe) begin
        snap    <= shadow;
        snap_go <= cfg_pending;
        late_wr <= wr_acc;
      end
      if (in_commit && snap_go) begin
        thr_active  <= snap;
        cfg_pending <= late_wr;
      end
      if (wr_acc) begin
        shadow[{wr_addr, 3'b000} +: 8] <= wr_data;
        cfg_pending                    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skin_count  <= '0;
      stats_valid <= 1'b0;
      frame_cnt   <= '0;
    end else if (in_commit && report) begin
      skin_count  <= count_hold;
      stats_valid <= 1'b1;
      frame_cnt   <= frame_cnt + 1'b1;
    end else begin
      stats_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_skin_bin_ctrl.sv
// tb/tb_skin_bin_ctrl.sv - scoreboard bench for skin_bin_ctrl against a frame-level reference model
module tb_skin_bin_ctrl;

  localparam int CNT_W  = 6;
  localparam int FCNT_W = 16;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              ce, de, vsync;
  logic [7:0]        skin;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              cfg_pending;
  logic [63:0]       thr_active;
  logic [CNT_W-1:0]  skin_count;
  logic              stats_valid;
  logic [FCNT_W-1:0] frame_cnt;

  skin_bin_ctrl #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .de          (de),
    .vsync       (vsync),
    .skin        (skin),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .cfg_pending (cfg_pending),
    .thr_active  (thr_active),
    .skin_count  (skin_count),
    .stats_valid (stats_valid),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          report;
    int          cnt;
    int          fnum;
    logic [63:0] active;
    bit          pending;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: frames, banks and counts as plain variables.
  logic [7:0] defaults [8] = '{8'd95, 8'd23, 8'd174, 8'd50, 8'd77, 8'd127, 8'd133, 8'd173};
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  bit m_vs_d, m_commit, m_started, m_pending;
  int m_cnt, m_frames;
  bit acc;

  function automatic logic [63:0] pack(input logic [7:0] b [8]);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  task automatic m_reset();
    m_vs_d = 0; m_commit = 0; m_started = 0; m_pending = 0;
    m_cnt = 0; m_frames = 0;
    m_shadow = defaults;
    m_active = defaults;
  endtask

  task automatic drive(input bit c, input bit d, input bit v, input logic [7:0] s,
                       input bit w, input logic [2:0] a, input logic [7:0] dat, output bit acc_o);
    bit fe, q;
    exp_t e;
    ce = c; de = d; vsync = v; skin = s; wr_en = w; wr_addr = a; wr_data = dat;
    check("wr_ready", wr_ready, !m_commit);
    acc_o = w && !m_commit;
    fe = c && v && !m_vs_d;
    if (c) m_vs_d = v;
    q = c && d && (s != 0);
    if (fe) begin
      e.report = m_started;
      e.cnt    = m_cnt;
      if (m_started) m_frames++;
      e.fnum = m_frames;
      if (m_pending) m_active = m_shadow;
      e.active  = pack(m_active);
      e.pending = acc_o;
      exp_q.push_back(e);
      m_started = 1;
      m_cnt = q ? 1 : 0;
    end else if (m_started && q && m_cnt < SAT) begin
      m_cnt++;
    end
    if (acc_o) m_shadow[a] = dat;
    m_pending = fe ? acc_o : (m_pending || acc_o);
    m_commit = fe;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 8'h00, 0, 3'd0, 8'h00, acc);
  endtask

  task automatic pulse();
    drive(1, 0, 1, 8'h00, 0, 3'd0, 8'h00, acc);
    drive(1, 0, 0, 8'h00, 0, 3'd0, 8'h00, acc);
  endtask

  task automatic pixels(input int n, input int k);
    for (int i = 0; i < n; i++) drive(1, 1, 0, (i < k) ? 8'hFF : 8'h00, 0, 3'd0, 8'h00, acc);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] dat);
    int tries;
    tries = 0;
    do begin
      drive(1, 0, 0, 8'h00, 1, a, dat, acc);
      tries++;
    end while (!acc && tries < 4);
    check("wr_accept", acc, 1);
  endtask

  // Monitor: a COMMIT cycle (wr_ready low) pops one expectation, checked on the next cycle.
  bit   mon_chk;
  exp_t mon_cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_chk = 0;
    end else begin
      if (mon_chk) begin
        check("stats_valid", stats_valid, mon_cur.report);
        if (mon_cur.report) begin
          check("skin_count", skin_count, mon_cur.cnt);
          check("frame_cnt", frame_cnt, mon_cur.fnum[FCNT_W-1:0]);
        end
        check("thr_active", thr_active, mon_cur.active);
        check("cfg_pending_post", cfg_pending, mon_cur.pending);
        mon_chk = 0;
      end else begin
        check("stats_valid_idle", stats_valid, 0);
      end
      if (!wr_ready) begin
        check("commit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_cur = exp_q.pop_front();
          mon_chk = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    rst_n = 0; ce = 0; de = 0; vsync = 0; skin = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_thr", thr_active, pack(defaults));
    check("rst_wr_ready", wr_ready, 1);
    check("rst_pending", cfg_pending, 0);
    check("rst_skin_count", skin_count, 0);
    check("rst_stats_valid", stats_valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1;
    idle(3);

    // Three frames, no writes; second frame has 100 pixels with 37 skin.
    pulse();
    pixels(50, 10);
    pulse();
    pixels(100, 37);
    pulse();
    idle(2);
    check("frame_cnt_after_3", frame_cnt, 2);

    // Mid-frame write held in shadow until the frame edge.
    pixels(10, 3);
    wr(3'd4, 8'h60);
    pixels(5, 2);
    check("thr_hold_cb_min", thr_active[39:32], 8'd77);
    check("pending_set", cfg_pending, 1);
    pulse();
    idle(1);
    check("cb_min_committed", thr_active[39:32], 8'h60);

    // Write on the frame edge, another presented during COMMIT.
    pixels(8, 4);
    drive(1, 0, 1, 8'h00, 1, 3'd0, 8'h11, acc);
    check("fe_write_acc", acc, 1);
    wr(3'd7, 8'h22);
    pixels(6, 6);
    check("late_write_pending", cfg_pending, 1);
    pulse();
    idle(1);

    // ce toggling with de/skin high; vsync rise while ce is low.
    for (int i = 0; i < 20; i++) drive(i % 2 == 0, 1, 0, 8'hFF, 0, 3'd0, 8'h00, acc);
    drive(0, 0, 1, 8'h00, 0, 3'd0, 8'h00, acc);
    drive(1, 0, 1, 8'h00, 0, 3'd0, 8'h00, acc);
    drive(1, 0, 0, 8'h00, 0, 3'd0, 8'h00, acc);

    // Counter saturation, then a frame with a skin pixel on the edge cycle.
    pixels(80, 80);
    drive(1, 1, 1, 8'h01, 0, 3'd0, 8'h00, acc);
    pixels(5, 2);
    pulse();
    idle(1);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      int hi, len;
      hi  = $urandom_range(1, 3);
      len = $urandom_range(10, 40);
      for (int i = 0; i < hi; i++)
        drive($urandom % 4 != 0, $urandom % 2, 1, 8'h00, 0, 3'd0, 8'h00, acc);
      for (int i = 0; i < len; i++) begin
        logic [7:0] s;
        s = ($urandom % 2) ? 8'h00 : 8'($urandom_range(1, 255));
        drive($urandom % 4 != 0, $urandom % 2, 0, s, ($urandom % 8) == 0,
              3'($urandom % 8), 8'($urandom % 256), acc);
      end
    end
    pulse();
    idle(2);

    // Reset mid-frame after writes.
    wr(3'd2, 8'h33);
    pixels(5, 5);
    rst_n = 0;
    exp_q.delete();
    m_reset();
    @(posedge clk);
    #1;
    check("midrst_thr", thr_active, pack(defaults));
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_pending", cfg_pending, 0);
    rst_n = 1;
    idle(2);
    pulse();
    pixels(12, 4);
    pulse();
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/skin_bin_ctrl.md
# skin_bin_ctrl

Run-time configuration and frame-statistics controller for the skin-binarization datapath. It holds the eight 8-bit threshold registers that drive `skin_binarization` (R/H/S/Cb/Cr bounds). Host writes go to a shadow bank and are committed to the active bank only at a frame boundary (vsync rising edge), so thresholds never change mid-frame. It also counts skin pixels per frame and reports the count once per frame. It sits beside `skin_binarization` on the same pixel clock and observes its `skin`/`de_out`/`vsync_out` outputs.

## Interface
- `CNT_W`, 22, width of per-frame skin-pixel counter (covers 1920×1080)
- `FCNT_W`, 16, width of frame counter
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ce`  in  1  pixel clock enable; gates the pixel side only
- `de`  in  1  data enable from `skin_binarization.de_out`
- `vsync`  in  1  active-high vsync from `skin_binarization.vsync_out`
- `skin`  in  8  binarized pixel; nonzero = skin
- `wr_en`  in  1  config write request
- `wr_addr`  in  3  register index 0..7
- `wr_data`  in  8  register value
- `wr_ready`  out  1  write accepted when `wr_en & wr_ready`
- `cfg_pending`  out  1  shadow differs from active (write since last commit)
- `thr_active`  out  64  active bank, register k at bits [8k+7:8k]
- `skin_count`  out  CNT_W  skin pixels of last complete frame
- `stats_valid`  out  1  one-cycle pulse when `skin_count` updates
- `frame_cnt`  out  FCNT_W  completed frames since reset, wraps

## Operation
- Register map (index, reset default): 0 R_MIN 95, 1 S_MIN 23, 2 S_MAX 174, 3 H_MAX 50, 4 CB_MIN 77, 5 CB_MAX 127, 6 CR_MIN 133, 7 CR_MAX 173.
- Reset: shadow = active = defaults; `wr_ready`=1, `cfg_pending`=0, `skin_count`=0, `stats_valid`=0, `frame_cnt`=0, counter=0, state WAIT_FRAME, vsync_d=0.
- Frame edge `fe` = `ce & vsync & ~vsync_d`; vsync_d updates only when `ce`=1.
- FSM states:
  - WAIT_FRAME: counter held at 0. On `fe`, go to COMMIT with `report`=0.
  - RUN: count. On `fe`, latch counter into a holding register, clear counter, go to COMMIT with `report`=1.
  - COMMIT: lasts exactly one cycle, independent of `ce`. If `cfg_pending`, copy shadow to active and clear `cfg_pending`. If `report`, drive `skin_count` from the holding register, pulse `stats_valid`, and increment `frame_cnt`. Then go to RUN.
- Counting in RUN and COMMIT: +1 when `ce & de & (skin != 0)`. Saturates at 2^CNT_W−1. The pixel in the `fe` cycle belongs to the new frame (counter loads 1 if it qualifies).
- Write: accepted when `wr_en & wr_ready`. shadow[wr_addr] <= wr_data and `cfg_pending` <= 1. Not gated by `ce`.
- `wr_ready` = 0 only in COMMIT; writes presented then stall and are not lost.
- A write accepted in the same cycle as `fe` lands in the shadow but is not committed at this edge; `cfg_pending` stays 1 after COMMIT.
- Reset mid-frame: all state returns to reset values; the next `fe` is treated as the first (no report).

## Timing
- `fe` at edge N → COMMIT during cycle N+1 → `thr_active`, `skin_count`, `frame_cnt` valid and `stats_valid`=1 after edge N+1. `stats_valid` falls after edge N+2.
- `thr_active` is registered with no combinational path from `wr_*`.
- A vsync held high does not retrigger; the next `fe` needs vsync low for at least one `ce` cycle.

## Structure
- Package `skin_bin_pkg`: register index constants, the 8 reset defaults, state encoding (WAIT_FRAME, RUN, COMMIT).
- Sub-module `skin_frame_stats`: vsync edge detect, saturating counter, holding register. Exposes `fe`, `count_hold`.
- The top level holds the FSM, shadow/active banks and the write handshake.

## Test plan
- Reset, then 3 frames with vsync pulses and no writes → `thr_active` = defaults. First `fe` gives no `stats_valid`; second gives one pulse with the correct count; `frame_cnt`=2 after the third `fe`.
- Frame of 100 `de` pixels with 37 having `skin`=0xFF → `skin_count`=37, `stats_valid` one cycle, one cycle after `fe`.
- Write addr 4 = 0x60 mid-frame → `thr_active[39:32]` stays 77 until `fe`, becomes 0x60 at N+1, and `cfg_pending` 1→0.
- Write presented on the `fe` cycle and again during COMMIT:
  - first write → shadow only, `cfg_pending` stays 1;
  - second write → stalled one cycle by `wr_ready`=0, then accepted;
  - both committed at the next `fe`.
- `ce` toggling 1/0 with `de`/`skin` held high for 20 clk (10 enabled) → count +10. Vsync rise during `ce`=0 is detected at the next `ce`=1 cycle.
- Assert `rst_n` mid-frame after writes → defaults restored, `frame_cnt`=0, and the next `fe` produces no `stats_valid`.
